// File: rtl/alu_rf_sequencer.sv
// ---------------------------------------------------------------------------
// alu_rf_sequencer
//   Runs one register-file + ALU command at a time for the lab CPU:
//   accept (op, rs, rt, rd, wb) on a valid/ready handshake, read rs/rt,
//   drive the ALU, capture F/ZF/OF, optionally write F back to rd, then
//   pulse done. Fixed 5-cycle command period, 4 cycles accept-to-done.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op/rs/rt/rd/wb        command fields
//   rf_raddr_a/b, rf_rdata_a/b  regfile read ports (combinational read)
//   alu_a/b/op, alu_f/zf/of   ALU operands/opcode and result/flags
//   rf_we/waddr/wdata         regfile write port (one-cycle pulse)
//   res_f/zf/of               last captured ALU result and flags
//   busy, done                status: not IDLE / one-cycle completion
// ---------------------------------------------------------------------------
module alu_rf_sequencer #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int OP_W      = 3,
    parameter int ZERO_PROT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              cmd_wb,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_zf,
    input  logic              alu_of,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] res_f,
    output logic              res_zf,
    output logic              res_of,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              wb_q, wb_d;
    logic [DATA_W-1:0] opa_q, opa_d;
    logic [DATA_W-1:0] opb_q, opb_d;
    logic [DATA_W-1:0] resf_q, resf_d;
    logic              reszf_q, reszf_d;
    logic              resof_q, resof_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            resf_q  <= '0;
            reszf_q <= 1'b0;
            resof_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            resf_q  <= resf_d;
            reszf_q <= reszf_d;
            resof_q <= resof_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        wb_d    = wb_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        resf_d  = resf_q;
        reszf_d = reszf_q;
        resof_d = resof_q;
        unique case (state_q)
            S_IDLE: begin
                // cmd_ready is simply "state is IDLE", so valid alone qualifies.
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rs_d    = cmd_rs;
                    rt_d    = cmd_rt;
                    rd_d    = cmd_rd;
                    wb_d    = cmd_wb;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // Operands are frozen here, so rs==rd / rt==rd use the old value.
                opa_d   = rf_rdata_a;
                opb_d   = rf_rdata_b;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                resf_d  = alu_f;
                reszf_d = alu_zf;
                resof_d = alu_of;
                state_d = S_WB;
            end
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // All outputs come from registers or a state decode; the async reset of
    // state_q therefore drops rf_we immediately on a mid-command abort.
    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign rf_raddr_a = rs_q;
    assign rf_raddr_b = rt_q;
    assign alu_a      = opa_q;
    assign alu_b      = opb_q;
    assign alu_op     = op_q;
    assign rf_we      = (state_q == S_WB) && wb_q &&
                        !((ZERO_PROT != 0) && (rd_q == '0));
    assign rf_waddr   = rd_q;
    assign rf_wdata   = resf_q;
    assign res_f      = resf_q;
    assign res_zf     = reszf_q;
    assign res_of     = resof_q;

endmodule

// File: tb/tb_alu_rf_sequencer.sv
module tb_alu_rf_sequencer;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_wb;
    logic [OW-1:0] cmd_op, alu_op;
    logic [AW-1:0] cmd_rs, cmd_rt, cmd_rd, rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [DW-1:0] rf_rdata_a, rf_rdata_b, alu_a, alu_b, alu_f, rf_wdata, res_f;
    logic          alu_zf, alu_of, rf_we, res_zf, res_of, busy, done;

    always #5 clk = ~clk;

    alu_rf_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .OP_W(OW), .ZERO_PROT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_wb(cmd_wb),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .res_f(res_f), .res_zf(res_zf), .res_of(res_of),
        .busy(busy), .done(done)
    );

    // Behavioural ALU: 100 = ADD, 101 = SUB, anything else = AND.
    always_comb begin
        alu_f  = alu_a & alu_b;
        alu_of = 1'b0;
        case (alu_op)
            3'b100: begin
                alu_f  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'b101: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            default: ;
        endcase
        alu_zf = (alu_f == '0);
    end

    // Register file with a bench-side preload port; r0 is writable here so
    // only the sequencer's write-back suppression can keep it at zero.
    logic [DW-1:0] rf [32];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we)     rf[pre_addr] <= pre_data;
        else if (rf_we) rf[rf_waddr] <= rf_wdata;
    end
    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs, rt, rd;
        logic        wb;
        logic [31:0] va, vb, vd;
        logic [31:0] f;
        logic        zf, of;
    } vec_t;

    typedef struct {
        logic [31:0] f;
        logic        zf, of;
        logic [4:0]  rd;
        logic [31:0] regval;
    } exp_t;

    vec_t          vecs [8];
    exp_t          sb [$];
    logic [DW-1:0] shadow [32];
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the following negedge.
    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        shadow[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic wb);
        cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd; cmd_wb = wb;
    endtask

    // Holds valid until ready is seen (bounded), then completes the accept edge.
    task automatic handshake();
        int waited = 0;
        cmd_valid = 1'b1;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("accept_wait", (waited < 20) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat, input int start);
        lat = start;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("res_f", res_f, e.f);
            chk("res_zf", {31'd0, res_zf}, {31'd0, e.zf});
            chk("res_of", {31'd0, res_of}, {31'd0, e.of});
            chk("rf_rd", rf[e.rd], e.regval);
            shadow[e.rd] = e.regval;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] ea, eb, regval;
        int          lat;
        preload(v.rd, v.vd);
        preload(v.rs, v.va);
        preload(v.rt, v.vb);
        ea = shadow[v.rs];
        eb = shadow[v.rt];
        regval = (v.wb && v.rd != 5'd0) ? v.f : shadow[v.rd];
        sb.push_back('{v.f, v.zf, v.of, v.rd, regval});
        drive_cmd(v.op, v.rs, v.rt, v.rd, v.wb);
        handshake();
        cmd_valid = 1'b0;
        @(negedge clk);                       // READ
        chk($sformatf("v%0d_raddr_a", idx), {27'd0, rf_raddr_a}, {27'd0, v.rs});
        chk($sformatf("v%0d_raddr_b", idx), {27'd0, rf_raddr_b}, {27'd0, v.rt});
        chk($sformatf("v%0d_busy", idx), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d_ready_busy", idx), {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);                       // EXEC
        chk($sformatf("v%0d_alu_a", idx), alu_a, ea);
        chk($sformatf("v%0d_alu_b", idx), alu_b, eb);
        chk($sformatf("v%0d_alu_op", idx), {29'd0, alu_op}, {29'd0, v.op});
        @(negedge clk);                       // WB
        chk($sformatf("v%0d_rf_we", idx), {31'd0, rf_we},
            {31'd0, (v.wb && v.rd != 5'd0)});
        chk($sformatf("v%0d_rf_wdata", idx), rf_wdata, v.f);
        chk($sformatf("v%0d_done_early", idx), {31'd0, done}, 32'd0);
        wait_done(lat, 3);
        chk($sformatf("v%0d_latency", idx), lat, 32'd4);
        compare_pop();
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d_ready_after", idx), {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int done_cnt;

        vecs[0] = '{3'b100, 5'd1,  5'd2,  5'd3,  1'b1, 32'd5,          32'd7,          32'd0,          32'd12,         1'b0, 1'b0};
        vecs[1] = '{3'b101, 5'd4,  5'd5,  5'd6,  1'b1, 32'h0000_1234,  32'h0000_1234,  32'h0000_FFFF,  32'd0,          1'b1, 1'b0};
        vecs[2] = '{3'b100, 5'd1,  5'd2,  5'd7,  1'b1, 32'h7FFF_FFFF,  32'd1,          32'd0,          32'h8000_0000,  1'b0, 1'b1};
        vecs[3] = '{3'b100, 5'd1,  5'd2,  5'd0,  1'b1, 32'd3,          32'd4,          32'd0,          32'd7,          1'b0, 1'b0};
        vecs[4] = '{3'b101, 5'd8,  5'd9,  5'd10, 1'b0, 32'd10,         32'd3,          32'h0000_0055,  32'd7,          1'b0, 1'b0};
        vecs[5] = '{3'b101, 5'd11, 5'd12, 5'd11, 1'b1, 32'd100,        32'd30,         32'd0,          32'd70,         1'b0, 1'b0};
        vecs[6] = '{3'b101, 5'd13, 5'd14, 5'd15, 1'b1, 32'h8000_0000,  32'd1,          32'd0,          32'h7FFF_FFFF,  1'b0, 1'b1};
        vecs[7] = '{3'b100, 5'd16, 5'd17, 5'd18, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'd5,          32'd0,          1'b1, 1'b0};

        rst = 1'b0;
        cmd_valid = 1'b0;
        drive_cmd(3'b000, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);

        @(negedge clk);
        for (int r = 0; r < 32; r++) preload(r[4:0], 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rel_busy", {31'd0, busy}, 32'd0);
        chk("rel_res_f", res_f, 32'd0);
        chk("rel_res_flags", {30'd0, res_zf, res_of}, 32'd0);
        chk("rel_alu_a", alu_a, 32'd0);
        chk("rel_raddr_a", {27'd0, rf_raddr_a}, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Back-to-back: valid held through busy with junk fields that must
        // not be stored; the real second command appears in the DONE cycle.
        preload(5'd20, 32'd10);
        preload(5'd21, 32'd20);
        preload(5'd22, 32'd0);
        preload(5'd23, 32'd0);
        preload(5'd24, 32'h0000_0099);
        sb.push_back('{32'd30, 1'b0, 1'b0, 5'd22, 32'd30});
        drive_cmd(3'b100, 5'd20, 5'd21, 5'd22, 1'b1);
        handshake();
        drive_cmd(3'b100, 5'd20, 5'd20, 5'd24, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ready_c%0d", k), {31'd0, cmd_ready}, 32'd0);
        end
        chk("b2b_doneA", {31'd0, done}, 32'd1);
        compare_pop();
        sb.push_back('{32'd20, 1'b0, 1'b0, 5'd23, 32'd20});
        drive_cmd(3'b101, 5'd22, 5'd20, 5'd23, 1'b1);
        @(negedge clk);
        chk("b2b_ready_c5", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(lat, 0);
        chk("b2b_latB", lat, 32'd4);
        compare_pop();
        chk("b2b_junk_r24", rf[24], 32'h0000_0099);

        // Reset during WB: write must not land, no done pulse afterwards.
        @(negedge clk);
        preload(5'd25, 32'h0000_AAAA);
        preload(5'd26, 32'd1);
        preload(5'd27, 32'd2);
        drive_cmd(3'b100, 5'd26, 5'd27, 5'd25, 1'b1);
        handshake();
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstwb_we_before", {31'd0, rf_we}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rstwb_we_async", {31'd0, rf_we}, 32'd0);
        chk("rstwb_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstwb_rd_kept", rf[25], 32'h0000_AAAA);
        chk("rstwb_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rstwb_res_f", res_f, 32'd0);
        done_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("rstwb_no_done", done_cnt, 32'd0);

        run_vec(vecs[0], 8);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
